ram_fifo_ctrl: RTL and testbench
================================

// Module: ram_fifo_ctrl
// PURPOSE
//  Upstream controller for the 16x4 single-port RAM_4bit: turns a valid/ready push stream into a FIFO.
//  Drives the RAM write_en/address/data_in and reads data_out back into a one-entry output register.
//  Presents a valid/ready pop stream downstream. The RAM port is shared, so every cycle is a WRITE, a READ or IDLE.
//  Capacity = DEPTH RAM words + 1 output register.
// PARAMETERS
//  DATA_W  4   word width; matches the RAM data_in/data_out
//  ADDR_W  4   RAM address width
//  DEPTH   16  RAM words, = 2**ADDR_W (localparam, not overridable)
// PORTS
//  clk           in   1         sole clock, rising edge
//  rst_n         in   1         asynchronous, active-low reset
//  in_valid      in   1         push request
//  in_data       in   DATA_W    push word
//  in_ready      out  1         push accepted when in_valid&&in_ready at rising clk
//  out_valid     out  1         out_data holds FIFO head
//  out_data      out  DATA_W    head word (registered)
//  out_ready     in   1         pop when out_valid&&out_ready at rising clk
//  ram_write_en  out  1         to RAM write_en
//  ram_address   out  ADDR_W    to RAM address
//  ram_data_in   out  DATA_W    to RAM data_in
//  ram_data_out  in   DATA_W    from RAM data_out (combinational read of ram_address)
//  count         out  ADDR_W+1  words held (RAM + output reg), 0..DEPTH+1
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
//  - Reset: wr_ptr, rd_ptr and ram_cnt go to 0; out_valid=0, out_data=0, count=0, init_done=0.
//    With rst_n low, in_ready=0 and ram_write_en=0.
//    Reset mid-operation discards all data. RAM contents are not cleared and never read back before a new write.
//  - init_done sets on the first rising clk after deassertion. in_ready=0 until it is set.
//  - Port grant (combinational, once per cycle):
//    - READ when ram_cnt!=0 and (!out_valid or out_ready).
//      ram_address=rd_ptr, ram_write_en=0. At the edge: out_data<=ram_data_out, out_valid<=1, rd_ptr++, ram_cnt--.
//    - Otherwise WRITE when in_valid and in_ready.
//      ram_address=wr_ptr, ram_data_in=in_data, ram_write_en=1. At the edge: wr_ptr++, ram_cnt++.
//    - Otherwise IDLE: ram_write_en=0, ram_address=rd_ptr.
//  - in_ready = init_done && ram_cnt!=DEPTH && grant!=READ. A read prefetch has priority over a push.
//  - Pop without READ: out_valid&&out_ready with ram_cnt==0 -> out_valid<=0.
//  - No bypass. A word pushed at edge E0 reaches out_valid after edge E1 at the earliest, if the RAM was otherwise empty.
//  - Pointers are ADDR_W bits and wrap F->0 silently. ram_cnt is ADDR_W+1 bits.
//  - count = ram_cnt + out_valid. It updates the same edge as the push/pop and changes by at most 1 per edge.
//  - Full: ram_cnt==DEPTH. Then in_ready=0 and in_valid is ignored; data is never overwritten.
//  - Empty: count==0. Then out_valid=0; out_ready is ignored.
//  - Simultaneous pop + push with ram_cnt>0 -> READ wins. Push stalls 1 cycle; the bench must see in_ready=0 that cycle.
//  - ram_write_en is never 1 in a READ cycle. ram_address/ram_data_in are stable from posedge to posedge (driven from regs+inputs).
//  - Ordering is strict FIFO: no reorder, duplicate or drop under any stall pattern.
// STRUCTURE
//  - Package ram_fifo_pkg: DATA_W, ADDR_W, DEPTH localparams; grant_t enum {G_IDLE, G_WRITE, G_READ}.
//  - One sub-module: fifo_wrap_ptr (ADDR_W-bit pointer with inc enable, async active-low clear), instanced for wr and rd.
//  - RAM_4bit stays outside; ram_fifo_ctrl only drives its ports.
// TESTING
//  1. Reset/init: rst_n=0 for 3 clk, then release.
//     -> out_valid=0, count=0, ram_write_en=0, in_ready=0 in cycle 1, in_ready=1 from cycle 2.
//  2. Push E,C,B,D with out_ready=0.
//     -> RAM writes addr 0..3; READ of addr0 preempts one push.
//     -> out_data=E, out_valid=1, count=4; then pop 4 -> E,C,B,D in order, count 0.
//  3. Fill: push 17 words 0..F,0 with out_ready=0.
//     -> count=17, in_ready=0, 18th word (5) not accepted; drain returns 0..F,0 exactly.
//  4. Wrap: push/pop 40 words continuously (in_data=i mod 16, out_ready=1).
//     -> pointers pass F->0 twice, output sequence equals input, no ram_write_en during READ.
//  5. Contention: ram_cnt=2, out_valid=1, out_ready=1, in_valid=1.
//     -> that cycle grant=READ, in_ready=0, push taken next cycle.
//  6. Reset mid-stream: 6 words held, drop rst_n between edges.
//     -> out_valid, count, in_ready go 0 immediately. After release push 9 -> first pop returns 9.

Source files
------------

// File: rtl/ram_fifo_pkg.sv
// Shared sizing and port-grant encoding for the RAM-backed FIFO controller.
package ram_fifo_pkg;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {G_IDLE, G_WRITE, G_READ} grant_t;
endpackage

// File: rtl/fifo_wrap_ptr.sv
// Wrapping RAM pointer: advances by one when inc is high, rolls over silently.
module fifo_wrap_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] ptr
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (inc)
      ptr <= ptr + 1'b1;
  end
endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around a single-port 16x4 RAM with a one-word registered output stage.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic [ADDR_W:0]   count
);
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   ram_cnt;
  logic              init_done;
  logic              read_req;
  grant_t            grant;

  // Refilling the output register outranks a push, so the head never stalls behind writes.
  assign read_req = (ram_cnt != '0) && (!out_valid || out_ready);
  assign in_ready = init_done && (ram_cnt != (ADDR_W + 1)'(DEPTH)) && !read_req;

  always_comb begin
    grant = G_IDLE;
    if (read_req)
      grant = G_READ;
    else if (in_valid && in_ready)
      grant = G_WRITE;
  end

  assign ram_write_en = (grant == G_WRITE);
  assign ram_address  = (grant == G_WRITE) ? wr_ptr : rd_ptr;
  assign ram_data_in  = in_data;
  assign count        = ram_cnt + {{ADDR_W{1'b0}}, out_valid};

  fifo_wrap_ptr #(.W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (grant == G_WRITE),
    .ptr   (wr_ptr)
  );

  fifo_wrap_ptr #(.W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (grant == G_READ),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      init_done <= 1'b0;
    else
      init_done <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ram_cnt <= '0;
    else if (grant == G_READ)
      ram_cnt <= ram_cnt - 1'b1;
    else if (grant == G_WRITE)
      ram_cnt <= ram_cnt + 1'b1;
  end

  // A pop with nothing left in RAM simply empties the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (grant == G_READ) begin
      out_valid <= 1'b1;
      out_data  <= ram_data_out;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl: behavioural RAM, queue-based FIFO model, directed and random traffic.
module tb_ram_fifo_ctrl;
  import ram_fifo_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic              ram_write_en;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;
  logic [ADDR_W:0]   count;

  int checks = 0;
  int failures = 0;

  ram_fifo_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .ram_write_en (ram_write_en),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out),
    .count        (count)
  );

  always #5 clk = ~clk;

  // Stand-in for RAM_4bit: combinational read, write on the rising edge.
  logic [DATA_W-1:0] mem [DEPTH];
  assign ram_data_out = mem[ram_address];
  always @(posedge clk) if (ram_write_en) mem[ram_address] <= ram_data_in;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: every held word in order, plus whether the head sits in the output register.
  logic [DATA_W-1:0] q[$];
  bit ov, init, rd, wr, exp_ready;
  int wr_total, rd_total, ram_words;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      ov = 0; init = 0; wr_total = 0; rd_total = 0;
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_count", count, 0);
      checkOutput("rst_write_en", ram_write_en, 0);
    end else begin
      ram_words = q.size() - int'(ov);
      rd        = (ram_words != 0) && (!ov || out_ready);
      exp_ready = init && (ram_words != DEPTH) && !rd;
      wr        = in_valid && exp_ready;
      checkOutput("in_ready", in_ready, exp_ready);
      checkOutput("out_valid", out_valid, ov);
      checkOutput("count", count, q.size());
      checkOutput("ram_write_en", ram_write_en, wr);
      checkOutput("ram_address", ram_address, wr ? wr_total % DEPTH : rd_total % DEPTH);
      if (wr) checkOutput("ram_data_in", ram_data_in, in_data);
      if (ov && out_ready) begin
        checkOutput("pop_data", out_data, q[0]);
        void'(q.pop_front());
      end
      if (wr) begin
        q.push_back(in_data);
        wr_total++;
      end
      if (rd) begin
        ov = 1;
        rd_total++;
      end else if (ov && out_ready) begin
        ov = 0;
      end
      init = 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic r);
    in_valid = v; in_data = d; out_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic pushWord(input logic [DATA_W-1:0] d);
    bit done = 0;
    int n = 0;
    in_valid = 1'b1; in_data = d;
    while (!done && n < 50) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!done) checkOutput("push_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (count != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain_empty", count, 0);
    out_ready = 1'b0;
  endtask

  logic [DATA_W-1:0] t2_words [4] = '{4'hE, 4'hC, 4'hB, 4'hD};

  initial begin
    int sent, n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("init_ready_cycle1", in_ready, 0);
    idle(1);
    checkOutput("init_ready_cycle2", in_ready, 1);

    // Push E,C,B,D with the consumer stalled, then drain in order.
    for (int i = 0; i < 4; i++) pushWord(t2_words[i]);
    idle(3);
    checkOutput("t2_count", count, 4);
    checkOutput("t2_out_valid", out_valid, 1);
    checkOutput("t2_head", out_data, 4'hE);
    drain();

    // Fill to 17 words; a further push must be refused.
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) pushWord(4'(i % 16));
    in_valid = 1'b1; in_data = 4'h5;
    repeat (3) begin
      @(negedge clk);
      checkOutput("t3_full_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checkOutput("t3_count", count, 17);
    drain();

    // Continuous streaming through two pointer wraps.
    out_ready = 1'b1; sent = 0; n = 0;
    while (sent < 40 && n < 300) begin
      in_valid = 1'b1; in_data = 4'(sent % 16);
      @(negedge clk);
      if (in_ready) sent++;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    checkOutput("t4_sent", sent, 40);
    drain();

    // Pop and push in the same cycle with words in RAM: the read wins.
    out_ready = 1'b0;
    pushWord(4'h1); pushWord(4'h2); pushWord(4'h3);
    idle(3);
    checkOutput("t5_count", count, 3);
    in_valid = 1'b1; in_data = 4'h7; out_ready = 1'b1;
    @(negedge clk);
    checkOutput("t5_contend_ready", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("t5_push_next", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Random traffic: a filling phase, then a draining phase.
    repeat (200) applyStimulus(1'($urandom), 4'($urandom), ($urandom % 4) == 0);
    repeat (200) applyStimulus(1'($urandom), 4'($urandom), ($urandom % 4) != 0);
    drain();

    // Asynchronous reset with data held, then fresh traffic.
    for (int i = 0; i < 6; i++) pushWord(4'(10 + i));
    idle(2);
    checkOutput("t6_count_before", count, 6);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_out_valid", out_valid, 0);
    checkOutput("t6_count", count, 0);
    checkOutput("t6_in_ready", in_ready, 0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    pushWord(4'h9);
    idle(3);
    checkOutput("t6_head", out_data, 4'h9);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
